// File: rtl/lsu_bus_adapter_if.sv
// rtl/lsu_bus_adapter_if.sv - memory op encoding plus pipeline-side and bus-side interfaces of the LSU
package lsu_pkg;
    typedef enum logic [3:0] {
        MEM_NOP = 4'd0,
        MEM_SB  = 4'd1,
        MEM_SH  = 4'd2,
        MEM_SW  = 4'd3,
        MEM_LB  = 4'd4,
        MEM_LH  = 4'd5,
        MEM_LW  = 4'd6,
        MEM_LBU = 4'd7,
        MEM_LHU = 4'd8
    } mem_op_t;
endpackage

interface lsu_req_if #(
    parameter int ADDR_W = 32
);
    logic                req_valid;
    logic                req_ready;
    lsu_pkg::mem_op_t    req_op;
    logic [ADDR_W-1:0]   req_addr;
    logic [31:0]         req_wdata;
    logic                stall;
    logic                resp_valid;
    logic [31:0]         resp_rdata;
    logic                resp_err;

    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        input  req_ready, stall, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        output req_ready, stall, resp_valid, resp_rdata, resp_err
    );
endinterface

interface lsu_mem_if #(
    parameter int ADDR_W = 32,
    parameter int BUS_W  = 32
);
    localparam int NB = BUS_W / 8;

    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [NB-1:0]     bus_be;
    logic [BUS_W-1:0]  bus_wdata;
    logic              bus_gnt;
    logic              bus_rvalid;
    logic [BUS_W-1:0]  bus_rdata;
    logic              bus_err;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata, bus_err
    );
    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata, bus_err
    );
endinterface

// File: rtl/lsu_bus_adapter.sv
// rtl/lsu_bus_adapter.sv - load/store unit bridging the MEM stage to a byte-enabled data bus
// Define LSU_MISALIGN_SPLIT_EN to issue bus-word-crossing misaligned accesses as two beats.
module lsu_bus_adapter #(
    parameter int ADDR_W = 32,
    parameter int BUS_W  = 32
) (
    input  logic      clk,
    input  logic      rst,
    lsu_req_if.slave  req,
    lsu_mem_if.master bus
);
    import lsu_pkg::*;

    localparam int NB    = BUS_W / 8;
    localparam int OFF_W = $clog2(NB);

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2, RESP} state_t;

    function automatic logic [2:0] op_size(input mem_op_t op);
        case (op)
            MEM_SB, MEM_LB, MEM_LBU: return 3'd1;
            MEM_SH, MEM_LH, MEM_LHU: return 3'd2;
            MEM_SW, MEM_LW:          return 3'd4;
            default:                 return 3'd0;
        endcase
    endfunction

    function automatic logic is_store(input mem_op_t op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic is_load(input mem_op_t op);
        return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
               (op == MEM_LBU) || (op == MEM_LHU);
    endfunction

    function automatic logic [31:0] extend(input mem_op_t op, input logic [31:0] raw);
        case (op)
            MEM_LB:  return {{24{raw[7]}}, raw[7:0]};
            MEM_LBU: return {24'd0, raw[7:0]};
            MEM_LH:  return {{16{raw[15]}}, raw[15:0]};
            MEM_LHU: return {16'd0, raw[15:0]};
            MEM_LW:  return raw;
            default: return 32'd0;
        endcase
    endfunction

    state_t            state_q, state_d;
    mem_op_t           op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [BUS_W-1:0]  lo_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic               accept, ld_lo, finish;
    logic [2:0]         in_size, size_q;
    logic               in_misaligned, crosses;
    logic [OFF_W-1:0]   off;
    logic [NB-1:0]      mask;
    logic [2*NB-1:0]    be_wide;
    logic [2*BUS_W-1:0] wd_wide, rd_wide;
    logic [31:0]        rd_raw;
    logic [ADDR_W-1:0]  base;
    logic               active, second, store_q;

    // Lane placement works on a double-width window so the upper half is beat 2.
    always_comb begin
        in_size       = op_size(req.req_op);
        in_misaligned = ((in_size == 3'd2) && req.req_addr[0]) ||
                        ((in_size == 3'd4) && (req.req_addr[1:0] != 2'b00));
        size_q  = op_size(op_q);
        store_q = is_store(op_q);
        off     = addr_q[OFF_W-1:0];
        crosses = (int'(off) + int'(size_q)) > NB;
        base    = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        mask    = '0;
        case (size_q)
            3'd1:    mask[0]   = 1'b1;
            3'd2:    mask[1:0] = 2'b11;
            3'd4:    mask[3:0] = 4'b1111;
            default: mask      = '0;
        endcase
        be_wide = {{NB{1'b0}}, mask} << off;
        wd_wide = {{(2*BUS_W-32){1'b0}}, wdata_q} << {off, 3'b000};
        rd_wide = (state_q == WAIT2) ? {bus.bus_rdata, lo_q}
                                     : {{BUS_W{1'b0}}, bus.bus_rdata};
        rd_raw  = 32'(rd_wide >> {off, 3'b000});
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        ld_lo   = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req.req_valid) begin
                    accept = 1'b1;
                    if ((in_size == 3'd0) || (in_misaligned && !SPLIT_EN))
                        state_d = RESP;
                    else
                        state_d = REQ1;
                end
            end
            REQ1: if (bus.bus_gnt) state_d = WAIT1;
            WAIT1: begin
                if (bus.bus_rvalid) begin
                    if (!bus.bus_err && SPLIT_EN && crosses) begin
                        ld_lo   = 1'b1;
                        state_d = REQ2;
                    end else begin
                        finish  = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            REQ2: if (bus.bus_gnt) state_d = WAIT2;
            WAIT2: begin
                if (bus.bus_rvalid) begin
                    finish  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= MEM_NOP;
            addr_q  <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= req.req_op;
                addr_q  <= req.req_addr;
                wdata_q <= is_store(req.req_op) ? req.req_wdata : 32'd0;
                rdata_q <= '0;
                err_q   <= in_misaligned && !SPLIT_EN;
            end
            if (ld_lo) lo_q <= bus.bus_rdata;
            // A faulted access returns no data, even if a first beat succeeded.
            if (finish) begin
                err_q   <= bus.bus_err;
                rdata_q <= (is_load(op_q) && !bus.bus_err) ? extend(op_q, rd_raw) : 32'd0;
            end
        end
    end

    assign active = (state_q == REQ1) || (state_q == REQ2);
    assign second = (state_q == REQ2);

    assign req.req_ready  = (state_q == IDLE);
    assign req.stall      = (state_q != IDLE) || req.req_valid;
    assign req.resp_valid = (state_q == RESP);
    assign req.resp_rdata = (state_q == RESP) ? rdata_q : 32'd0;
    assign req.resp_err   = (state_q == RESP) && err_q;

    assign bus.bus_req   = active;
    assign bus.bus_we    = active && store_q;
    assign bus.bus_addr  = !active ? '0 : (second ? base + ADDR_W'(NB) : base);
    assign bus.bus_be    = !active ? '0 : (second ? be_wide[2*NB-1:NB] : be_wide[NB-1:0]);
    assign bus.bus_wdata = !(active && store_q) ? '0 :
                           (second ? wd_wide[2*BUS_W-1:BUS_W] : wd_wide[BUS_W-1:0]);
endmodule
